// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : parameterised UART transmitter (start, 5..9 data bits LSB first,
//           optional odd parity, one or two stop bits).
//
// Parameters
//   SYSCLK_FREQUENCY_HZ : sysclk frequency in Hz
//   BAUDRATE            : serial bit rate; each bit lasts SYSCLK/BAUD cycles
//   DATA_LENGTH         : payload bits per frame (5..9)
//   PARITY              : 1 -> odd parity bit follows the payload
//   DOUBLE_STOPBIT      : 1 -> two stop bits
//
// Ports
//   sysclk : system clock, rising edge
//   reset  : asynchronous active-high reset
//   send   : transmit request, accepted when ready is high
//   data   : payload, latched on acceptance
//   ready  : idle and able to accept a request
//   active : a frame is on the line
//   done   : one-cycle pulse after a frame completes
//   serial : registered UART line, idle level 1
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned SYSCLK_FREQUENCY_HZ = 100000000,
    parameter int unsigned BAUDRATE            = 115200,
    parameter int unsigned DATA_LENGTH         = 8,
    parameter logic        PARITY              = 1'b0,
    parameter logic        DOUBLE_STOPBIT      = 1'b0
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   send,
    input  logic [DATA_LENGTH-1:0] data,
    output logic                   ready,
    output logic                   active,
    output logic                   done,
    output logic                   serial
);

    localparam int unsigned RATIO     = SYSCLK_FREQUENCY_HZ / BAUDRATE;
    localparam int unsigned BAUD_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BIT_W     = $clog2(DATA_LENGTH);
    localparam int unsigned STOP_BITS = 1 + 32'(DOUBLE_STOPBIT);

    // Reject configurations the bit timing or counters cannot represent
    if (RATIO < 2) begin : g_bad_ratio
        $error("uart_tx: SYSCLK_FREQUENCY_HZ/BAUDRATE must be at least 2");
    end
    if (DATA_LENGTH < 5 || DATA_LENGTH > 9) begin : g_bad_length
        $error("uart_tx: DATA_LENGTH must be within 5..9");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]             state_q,  state_d;
    logic [BAUD_W-1:0]      baud_q,   baud_d;
    logic [BIT_W-1:0]       bit_q,    bit_d;
    logic [DATA_LENGTH-1:0] data_q,   data_d;
    logic                   par_q,    par_d;
    logic                   serial_q, serial_d;
    logic                   ready_q,  ready_d;
    logic                   active_q, active_d;
    logic                   done_q,   done_d;

    logic baud_last;

    // Last sysclk cycle of the current bit period
    assign baud_last = (baud_q == BAUD_W'(RATIO - 1));

    // State register; reset drives the line to mark level immediately
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic; serial_d is the level of the bit
    // about to start, so the line only changes on bit boundaries.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b1;
                active_d = 1'b0;
                serial_d = 1'b1;
                baud_d   = '0;
                bit_d    = '0;
                // ready_q gates acceptance so the first edge after reset
                // only raises ready
                if (send && ready_q) begin
                    state_d  = S_START;
                    data_d   = data;
                    par_d    = ~^data;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (baud_last) begin
                    state_d  = S_DATA;
                    baud_d   = '0;
                    bit_d    = '0;
                    serial_d = data_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            // data_q shifts right so bit 1 is always the next payload bit
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_LENGTH - 1)) begin
                        bit_d = '0;
                        if (PARITY) begin
                            state_d  = S_PAR;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        data_d   = data_q >> 1;
                        serial_d = data_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_PAR: begin
                if (baud_last) begin
                    state_d  = S_STOP;
                    baud_d   = '0;
                    bit_d    = '0;
                    serial_d = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            // bit_q counts stop bits here
            S_STOP: begin
                serial_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d  = S_IDLE;
                        bit_d    = '0;
                        ready_d  = 1'b1;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                ready_d  = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    assign serial = serial_q;
    assign ready  = ready_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed bench for uart_tx with RATIO=4, DATA_LENGTH=8.
//   dut1 : PARITY=1, DOUBLE_STOPBIT=0 (FRAME=44)
//   dut2 : PARITY=0, DOUBLE_STOPBIT=1 (FRAME=44)
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int FRAME = 44;
    localparam int RAT   = 4;

    logic       clk;
    logic       rst;
    logic       send1, send2;
    logic [7:0] data1, data2;
    logic       ready1, active1, done1, serial1;
    logic       ready2, active2, done2, serial2;

    int n_cmp;
    int n_bad;

    uart_tx #(
        .SYSCLK_FREQUENCY_HZ(400),
        .BAUDRATE           (100),
        .DATA_LENGTH        (8),
        .PARITY             (1'b1),
        .DOUBLE_STOPBIT     (1'b0)
    ) dut1 (
        .sysclk(clk),
        .reset (rst),
        .send  (send1),
        .data  (data1),
        .ready (ready1),
        .active(active1),
        .done  (done1),
        .serial(serial1)
    );

    uart_tx #(
        .SYSCLK_FREQUENCY_HZ(400),
        .BAUDRATE           (100),
        .DATA_LENGTH        (8),
        .PARITY             (1'b0),
        .DOUBLE_STOPBIT     (1'b1)
    ) dut2 (
        .sysclk(clk),
        .reset (rst),
        .send  (send2),
        .data  (data2),
        .ready (ready2),
        .active(active2),
        .done  (done2),
        .serial(serial2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic f_ser(input int w);
        return (w == 0) ? serial1 : serial2;
    endfunction
    function automatic logic f_rdy(input int w);
        return (w == 0) ? ready1 : ready2;
    endfunction
    function automatic logic f_act(input int w);
        return (w == 0) ? active1 : active2;
    endfunction
    function automatic logic f_done(input int w);
        return (w == 0) ? done1 : done2;
    endfunction

    // Called just after acceptance edge T. bits[i] is the i-th bit on the
    // line (bit 0 = start). Samples each bit in its second cycle, then checks
    // the end-of-frame handshake. chg_at/pulse_at poke dut1 inputs after
    // edge T+n; b2b expects the next frame's start bit after edge T+FRAME+1.
    task automatic check_frame(input int w, input logic [10:0] bits, input bit b2b,
                               input int chg_at, input int pulse_at, input string tag);
        int idx;
        chk($sformatf("%s:t1_serial", tag), f_ser(w), 1'b0);
        chk($sformatf("%s:t1_ready", tag), f_rdy(w), 1'b0);
        chk($sformatf("%s:t1_active", tag), f_act(w), 1'b1);
        for (int e = 1; e <= FRAME + 1; e++) begin
            tick();
            if (e == chg_at) data1 = 8'h00;
            if (e == pulse_at) send1 = 1'b1;
            if (e == pulse_at + 1) send1 = 1'b0;
            if ((e - 1) % RAT == 0 && (e - 1) / RAT < 11) begin
                idx = (e - 1) / RAT;
                chk($sformatf("%s:bit%0d", tag, idx), f_ser(w), bits[idx]);
            end
            if (e == FRAME - 1) begin
                chk($sformatf("%s:last_ready", tag), f_rdy(w), 1'b0);
                chk($sformatf("%s:last_active", tag), f_act(w), 1'b1);
                chk($sformatf("%s:last_done", tag), f_done(w), 1'b0);
            end
            if (e == FRAME) begin
                chk($sformatf("%s:end_done", tag), f_done(w), 1'b1);
                chk($sformatf("%s:end_ready", tag), f_rdy(w), 1'b1);
                chk($sformatf("%s:end_active", tag), f_act(w), 1'b0);
                chk($sformatf("%s:end_serial", tag), f_ser(w), 1'b1);
            end
            if (e == FRAME + 1) begin
                chk($sformatf("%s:post_done", tag), f_done(w), 1'b0);
                chk($sformatf("%s:post_serial", tag), f_ser(w), b2b ? 1'b0 : 1'b1);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        send1 = 1'b0;
        send2 = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_serial", serial1, 1'b1);
        chk("rst_ready", ready1, 1'b0);
        chk("rst_active", active1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_serial2", serial2, 1'b1);

        // First edge after release raises ready, no done
        rst = 1'b0;
        tick();
        chk("rel_ready", ready1, 1'b1);
        chk("rel_done", done1, 1'b0);
        chk("rel_ready2", ready2, 1'b1);

        // 0xA7 with parity 0; stray send pulse at T+10 must be ignored
        data1 = 8'hA7;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        check_frame(0, {1'b1, 1'b0, 8'hA7, 1'b0}, 1'b0, -1, 9, "a7");
        tick();
        chk("a7_no_queue_active", active1, 1'b0);
        chk("a7_no_queue_serial", serial1, 1'b1);

        // 0x27 with parity 1; data cleared during the frame
        data1 = 8'h27;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        check_frame(0, {1'b1, 1'b1, 8'h27, 1'b0}, 1'b0, 4, -1, "27_hold");

        // Back-to-back with send held high
        data1 = 8'hA7;
        send1 = 1'b1;
        tick();
        data1 = 8'h27;
        check_frame(0, {1'b1, 1'b0, 8'hA7, 1'b0}, 1'b1, -1, -1, "b2b_a");
        send1 = 1'b0;
        check_frame(0, {1'b1, 1'b1, 8'h27, 1'b0}, 1'b0, -1, -1, "b2b_b");

        // No parity, two stop bits
        data2 = 8'hA7;
        send2 = 1'b1;
        tick();
        send2 = 1'b0;
        check_frame(1, {2'b11, 8'hA7, 1'b0}, 1'b0, -1, -1, "d2_a7");
        data2 = 8'h27;
        send2 = 1'b1;
        tick();
        send2 = 1'b0;
        check_frame(1, {2'b11, 8'h27, 1'b0}, 1'b0, -1, -1, "d2_27");

        // Reset at T+20 aborts the frame and forces the line high at once
        data1 = 8'hA7;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        repeat (19) tick();
        chk("abort_pre_serial", serial1, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_serial", serial1, 1'b1);
        chk("abort_ready", ready1, 1'b0);
        chk("abort_active", active1, 1'b0);
        chk("abort_done", done1, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("abort_rel_ready", ready1, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk($sformatf("abort_quiet%0d", i), done1 | active1 | ~serial1, 1'b0);
        end

        // Full frame after recovery
        data1 = 8'h27;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        check_frame(0, {1'b1, 1'b1, 8'h27, 1'b0}, 1'b0, -1, -1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter SYSCLK_FREQUENCY_HZ, default 100000000, the sysclk frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115200, the serial bit rate.
REQ-003 Parameter DATA_LENGTH, default 8, the number of payload bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 1'b0; when 1, an odd-parity bit SHALL follow the payload.
REQ-005 Parameter DOUBLE_STOPBIT, default 1'b0; when 1, two stop bits SHALL be sent.
REQ-006 sysclk  input  1  system clock; all logic SHALL act on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 send  input  1  request to transmit the value on data.
REQ-009 data  input  DATA_LENGTH  payload to transmit.
REQ-010 ready  output  1  high when idle and able to accept a request.
REQ-011 active  output  1  high while a frame is on the line.
REQ-012 done  output  1  one-cycle pulse after a frame completes.
REQ-013 serial  output  1  registered UART line; idle/mark level is 1.

Function
REQ-014 RATIO = SYSCLK_FREQUENCY_HZ/BAUDRATE (integer division); each bit SHALL last exactly RATIO sysclk cycles; elaboration SHALL fail if RATIO < 2 or DATA_LENGTH is outside 5..9.
REQ-015 FRAME = RATIO*(1 + DATA_LENGTH + PARITY + 1 + DOUBLE_STOPBIT) cycles.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP; PAR SHALL be skipped when PARITY=0.
REQ-017 Acceptance: send=1 and ready=1 at edge T; data SHALL be latched at T, and later changes to data SHALL be ignored until the next acceptance.
REQ-018 send asserted while ready=0 SHALL be ignored, with no queuing.
REQ-019 serial SHALL be 0 (start bit) from cycle T+1 to T+RATIO.
REQ-020 Payload bits SHALL be sent LSB first, one bit per RATIO cycles.
REQ-021 When PARITY=1, the parity bit SHALL equal the XNOR-reduction of the latched data, making the total count of ones in payload plus parity odd.
REQ-022 Stop bit(s) SHALL be 1 and SHALL end at cycle T+FRAME.
REQ-023 ready SHALL be 0 and active SHALL be 1 from cycle T+1 to T+FRAME inclusive.
REQ-024 At cycle T+FRAME+1 the FSM SHALL be in IDLE, ready SHALL be 1, active SHALL be 0 and done SHALL be 1 for exactly one cycle.
REQ-025 Back-to-back: if send is held high, the next acceptance SHALL occur at T+FRAME+1, giving exactly one idle cycle of serial=1 between frames.
REQ-026 A bit counter and a baud counter of width clog2 SHALL be used; both SHALL reset to 0 at each state entry, with no wrap glitch on the line.
REQ-027 serial SHALL change only at bit boundaries, with no single-cycle glitches.

Reset
REQ-028 While reset=1: serial=1, ready=0, active=0, done=0, FSM in IDLE, and all counters and the data register cleared.
REQ-029 The first edge after reset deasserts SHALL set ready=1; reset never generates done.
REQ-030 Reset asserted mid-frame SHALL force serial=1 immediately (asynchronously) and abort the frame; no partial-frame completion SHALL follow.

Verification (RATIO=4, DATA_LENGTH=8, PARITY=1, DOUBLE_STOPBIT=0, FRAME=44)
REQ-031 send data=8'hA7 -> serial, sampled at each bit centre, reads 0,1,1,1,0,0,1,0,1,0(par),1(stop); done pulses at T+45.
REQ-032 data=8'h27 -> parity bit 1; data changed to 8'h00 at T+5 -> the transmitted payload is still 8'h27.
REQ-033 send held high with 8'hA7 then 8'h27 -> two frames separated by exactly one idle cycle; a send pulse at T+10 is ignored.
REQ-034 reset asserted at T+20 -> serial=1 in the same cycle, no done; a new send after release produces a full frame.
REQ-035 Loopback into uart_rx with matching parameters for 8'hA7 and 8'h27 -> receiver ready=1, error=0, data matches; with PARITY=0 and DOUBLE_STOPBIT=1, FRAME=44 and the receiver still matches.
